pipe_run_ctrl: RTL and testbench

Run sequencer for the floating-point pipeline inside the processor user-datapath module. It sits between the generic register block and the pipeline. It owns the pipeline soft reset, the pipeline enable and the shared memory port. It runs host commands: soft reset, run for N cycles, and dump N result words. Between commands it arbitrates single host memory accesses onto the same port.

---
 rtl/pipe_run_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pipe_run_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_run_ctrl
// Brief    : Run sequencer for the FP pipeline: soft reset, timed run, result
//            dump, and host memory access arbitration on one memory port.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_run_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 4,
  parameter int RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_arg,
  input  logic [1:0]        cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              abort,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [1:0]        host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [31:0]       host_rdata,
  output logic              pipe_rst,
  output logic              pipe_en,
  output logic              mem_we,
  output logic              mem_re,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              dump_valid,
  output logic [31:0]       dump_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [31:0]       cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SRST  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DUMP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [1:0] OP_SRST = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_DUMP = 2'd2;

  localparam logic [RD_LAT-1:0] C_TAG_LAST = RD_LAT'(1) << (RD_LAT - 1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_cycles;
  logic              r_aborted;
  logic              r_done;
  logic              r_pipe_rst;
  logic              r_pipe_en;
  logic              r_mem_we;
  logic              r_mem_re;
  logic              r_rd_dump;
  logic [1:0]        r_mem_sel;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [RD_LAT-1:0] r_dump_tag;
  logic [RD_LAT-1:0] r_host_tag;

  logic              w_accept;
  logic              w_gnt;
  logic              w_abort;
  logic              w_dump_last;
  logic [RD_LAT-1:0] w_dump_next;
  logic [RD_LAT-1:0] w_host_next;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_gnt    = host_req && (r_state == S_IDLE) && !cmd_valid;
  assign w_abort  = abort && ((r_state == S_RUN) || (r_state == S_DUMP) || (r_state == S_DRAIN));

  // Tag pipes track each read until its data is on mem_rdata at the last stage.
  always_comb begin
    w_dump_next    = r_dump_tag << 1;
    w_dump_next[0] = r_mem_re && r_rd_dump;
    w_host_next    = r_host_tag << 1;
    w_host_next[0] = r_mem_re && !r_rd_dump;
  end

  // Final beat reaches the output stage at this edge with nothing behind it.
  assign w_dump_last = ((r_state == S_DRAIN) || ((r_state == S_DUMP) && (r_cnt == '0)))
                       && (w_dump_next == C_TAG_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cycles    <= '0;
      r_aborted   <= 1'b0;
      r_done      <= 1'b0;
      r_pipe_rst  <= 1'b0;
      r_pipe_en   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_rd_dump   <= 1'b0;
      r_mem_sel   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dump_tag  <= '0;
      r_host_tag  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_mem_we   <= 1'b0;
      r_dump_tag <= w_abort ? '0 : w_dump_next;
      r_host_tag <= w_host_next;
      if (r_pipe_en && (r_cycles != '1)) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (w_abort) begin
        r_state   <= S_IDLE;
        r_pipe_en <= 1'b0;
        r_mem_re  <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_mem_re <= 1'b0;
            if (w_accept) begin
              r_aborted <= 1'b0;
              r_cycles  <= '0;
              r_cnt     <= cmd_arg - CNT_W'(1);
              case (cmd_op)
                OP_SRST: begin
                  r_state    <= S_SRST;
                  r_pipe_rst <= 1'b1;
                  r_cnt      <= CNT_W'(RST_CYCLES - 1);
                end
                OP_RUN: begin
                  if (cmd_arg != '0) begin
                    r_state   <= S_RUN;
                    r_pipe_en <= 1'b1;
                  end else begin
                    r_done <= 1'b1;
                  end
                end
                OP_DUMP: begin
                  if (cmd_arg != '0) begin
                    r_state    <= S_DUMP;
                    r_mem_re   <= 1'b1;
                    r_rd_dump  <= 1'b1;
                    r_mem_sel  <= cmd_sel;
                    r_mem_addr <= cmd_addr;
                  end else begin
                    r_done <= 1'b1;
                  end
                end
                default: r_done <= 1'b1;
              endcase
            end else if (w_gnt) begin
              r_mem_we    <= host_we;
              r_mem_re    <= !host_we;
              r_rd_dump   <= 1'b0;
              r_mem_sel   <= host_sel;
              r_mem_addr  <= host_addr;
              r_mem_wdata <= host_wdata;
            end
          end
          S_SRST: begin
            if (r_cnt == '0) begin
              r_pipe_rst <= 1'b0;
              r_state    <= S_IDLE;
              r_done     <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_RUN: begin
            if (r_cnt == '0) begin
              r_pipe_en <= 1'b0;
              r_state   <= S_IDLE;
              r_done    <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_DUMP: begin
            if (r_cnt == '0) begin
              r_mem_re <= 1'b0;
              r_state  <= w_dump_last ? S_IDLE : S_DRAIN;
              r_done   <= w_dump_last;
            end else begin
              r_mem_re   <= 1'b1;
              r_cnt      <= r_cnt - CNT_W'(1);
              r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end
          end
          S_DRAIN: begin
            if (w_dump_last || (w_dump_next == '0)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign host_gnt    = w_gnt;
  assign host_rvalid = r_host_tag[RD_LAT-1];
  assign host_rdata  = host_rvalid ? mem_rdata : 32'd0;
  assign dump_valid  = r_dump_tag[RD_LAT-1];
  assign dump_data   = dump_valid ? mem_rdata : 32'd0;
  assign pipe_rst    = r_pipe_rst;
  assign pipe_en     = r_pipe_en;
  assign mem_we      = r_mem_we;
  assign mem_re      = r_mem_re;
  assign mem_sel     = r_mem_sel;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign cycles      = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_run_ctrl
// Brief    : Directed self-checking bench for pipe_run_ctrl with a bank memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_run_ctrl;
  localparam int ADDR_W     = 12;
  localparam int CNT_W      = 16;
  localparam int RST_CYCLES = 4;
  localparam int RD_LAT     = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_arg;
  logic [1:0]        cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic              abort;
  logic              host_req;
  logic              host_we;
  logic [1:0]        host_sel;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [31:0]       host_rdata;
  logic              pipe_rst;
  logic              pipe_en;
  logic              mem_we;
  logic              mem_re;
  logic [1:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              dump_valid;
  logic [31:0]       dump_data;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [31:0]       cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_run_ctrl #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .abort(abort),
    .host_req(host_req), .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .pipe_rst(pipe_rst), .pipe_en(pipe_en),
    .mem_we(mem_we), .mem_re(mem_re), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dump_valid(dump_valid),
    .dump_data(dump_data), .busy(busy), .done(done), .aborted(aborted), .cycles(cycles)
  );

  // Bank memory: unwritten words read back a fixed pattern of {sel, addr}.
  bit                wr_valid = 1'b0;
  logic [1:0]        wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_pipe [RD_LAT];

  function automatic logic [31:0] pattern(input logic [1:0] s, input logic [ADDR_W-1:0] a);
    return 32'hA500_0000 | {14'd0, s, 4'd0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      wr_valid <= 1'b1;
      wr_sel   <= mem_sel;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
    if (mem_re)
      rd_pipe[0] <= (wr_valid && wr_sel == mem_sel && wr_addr == mem_addr) ? wr_data
                                                                         : pattern(mem_sel, mem_addr);
    else
      rd_pipe[0] <= 32'd0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    tests++;
    if ({busy, done, aborted, pipe_rst, pipe_en, mem_we, mem_re, dump_valid, host_rvalid, host_gnt} !== 10'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0", {busy, done, aborted, pipe_rst, pipe_en, mem_we, mem_re, dump_valid, host_rvalid, host_gnt});
    end
    tests++; if (cycles !== 32'd0) begin fails++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
    tests++;
    if ({mem_sel, mem_addr, mem_wdata, dump_data, host_rdata} !== '0) begin
      fails++; $display("FAIL reset_buses: got %h want 0", {mem_sel, mem_addr, mem_wdata, dump_data, host_rdata});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_run();
    logic [7:0] pe_bits, done_bits;
    logic busy_seen;
    busy_seen = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 16'd5;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pe_bits[k] = pipe_en; done_bits[k] = done;
      if (k == 0) busy_seen = busy;
      tick();
    end
    tests++; if (pe_bits !== 8'h1F) begin fails++; $display("FAIL run_pipe_en: got %b want 00011111", pe_bits); end
    tests++; if (done_bits !== 8'h20) begin fails++; $display("FAIL run_done: got %b want 00100000", done_bits); end
    tests++; if (cycles !== 32'd5) begin fails++; $display("FAIL run_cycles: got %0d want 5", cycles); end
    tests++; if (busy_seen !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL run_busy: got %b%b want 10", busy_seen, busy); end
  endtask

  task automatic test_dump();
    logic [7:0]        re_bits, dv_bits, done_bits;
    logic [ADDR_W-1:0] addrs [4];
    logic [31:0]       datas [4];
    logic [ADDR_W-1:0] exp_addr [4];
    logic [31:0]       exp_data [4];
    int n_re, n_dv, bad_sel, n_we;
    exp_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    exp_data = '{32'hA503_0FFE, 32'hA503_0FFF, 32'hA503_0000, 32'hA503_0001};
    n_re = 0; n_dv = 0; bad_sel = 0; n_we = 0;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 16'd4; cmd_sel = 2'd3; cmd_addr = 12'hFFE;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      re_bits[k] = mem_re; dv_bits[k] = dump_valid; done_bits[k] = done;
      if (mem_we) n_we++;
      if (mem_re) begin
        if (mem_sel !== 2'd3) bad_sel++;
        if (n_re < 4) addrs[n_re] = mem_addr;
        n_re++;
      end
      if (dump_valid) begin
        if (n_dv < 4) datas[n_dv] = dump_data;
        n_dv++;
      end
      tick();
    end
    tests++; if (re_bits !== 8'h0F) begin fails++; $display("FAIL dump_mem_re: got %b want 00001111", re_bits); end
    tests++; if (dv_bits !== 8'h3C) begin fails++; $display("FAIL dump_valid: got %b want 00111100", dv_bits); end
    tests++; if (done_bits !== 8'h20) begin fails++; $display("FAIL dump_done: got %b want 00100000", done_bits); end
    tests++; if (bad_sel != 0 || n_we != 0) begin fails++; $display("FAIL dump_sel_we: got bad_sel=%0d we=%0d want 0 0", bad_sel, n_we); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= n_re || addrs[i] !== exp_addr[i]) begin
        fails++; $display("FAIL dump_addr[%0d]: got %h want %h", i, addrs[i], exp_addr[i]);
      end
      tests++;
      if (i >= n_dv || datas[i] !== exp_data[i]) begin
        fails++; $display("FAIL dump_data[%0d]: got %h want %h", i, datas[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [2:0] gnt_bits;
    host_req = 1'b1; host_we = 1'b0; host_sel = 2'd0; host_addr = 12'd5;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 16'd2;
    #1;
    tests++; if (host_gnt !== 1'b0) begin fails++; $display("FAIL arb_same_cycle_gnt: got %b want 0", host_gnt); end
    tick();
    cmd_valid = 1'b0;
    gnt_bits[0] = host_gnt; tick();
    gnt_bits[1] = host_gnt; tick();
    gnt_bits[2] = host_gnt;
    tests++; if (gnt_bits !== 3'b100) begin fails++; $display("FAIL arb_gnt_after_run: got %b want 100", gnt_bits); end
    tick();
    host_req = 1'b0;
    tests++;
    if ({mem_re, mem_we, mem_sel, mem_addr} !== {1'b1, 1'b0, 2'd0, 12'd5}) begin
      fails++; $display("FAIL arb_host_read_strobe: got re=%b we=%b sel=%0d addr=%h want 1 0 0 005", mem_re, mem_we, mem_sel, mem_addr);
    end
    tick();
    tests++; if (host_rvalid !== 1'b0) begin fails++; $display("FAIL arb_rvalid_early: got %b want 0", host_rvalid); end
    tick();
    tests++;
    if (host_rvalid !== 1'b1 || host_rdata !== 32'hA500_0005) begin
      fails++; $display("FAIL arb_host_rdata: got v=%b d=%h want 1 a5000005", host_rvalid, host_rdata);
    end
    tick();
  endtask

  task automatic test_abort();
    logic done_seen;
    logic [5:0] rst_bits, done_bits;
    done_seen = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 16'd100;
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin done_seen |= done; tick(); end
    tests++; if (pipe_en !== 1'b1) begin fails++; $display("FAIL abort_pre_pipe_en: got %b want 1", pipe_en); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({pipe_en, aborted, busy, done} !== 4'b0100) begin
      fails++; $display("FAIL abort_flags: got en/ab/busy/done=%b want 0100", {pipe_en, aborted, busy, done});
    end
    tests++; if (cycles !== 32'd10) begin fails++; $display("FAIL abort_cycles: got %0d want 10", cycles); end
    for (int k = 0; k < 4; k++) begin done_seen |= done | pipe_en; tick(); end
    tests++; if (done_seen !== 1'b0 || aborted !== 1'b1) begin fails++; $display("FAIL abort_no_done: got done_seen=%b aborted=%b want 0 1", done_seen, aborted); end
    // Soft reset clears the sticky flag and ignores abort while running.
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_arg = 16'd0;
    tick();
    cmd_valid = 1'b0;
    tests++; if (aborted !== 1'b0) begin fails++; $display("FAIL abort_cleared: got %b want 0", aborted); end
    abort = 1'b1;
    for (int k = 0; k < 6; k++) begin rst_bits[k] = pipe_rst; done_bits[k] = done; tick(); end
    abort = 1'b0;
    tests++; if (rst_bits !== 6'b001111) begin fails++; $display("FAIL srst_pipe_rst: got %b want 001111", rst_bits); end
    tests++; if (done_bits !== 6'b010000) begin fails++; $display("FAIL srst_done: got %b want 010000", done_bits); end
    tests++; if (aborted !== 1'b0) begin fails++; $display("FAIL srst_abort_ignored: got %b want 0", aborted); end
  endtask

  task automatic test_host_write_read();
    host_req = 1'b1; host_we = 1'b1; host_sel = 2'd1; host_addr = 12'd7; host_wdata = 32'hDEAD_BEEF;
    #1;
    tests++; if (host_gnt !== 1'b1) begin fails++; $display("FAIL hw_gnt: got %b want 1", host_gnt); end
    tick();
    host_we = 1'b0; host_wdata = 32'd0;
    tests++;
    if ({mem_we, mem_re, mem_sel, mem_addr, mem_wdata} !== {1'b1, 1'b0, 2'd1, 12'd7, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL hw_write_strobe: got we=%b re=%b sel=%0d addr=%h d=%h want 1 0 1 007 deadbeef", mem_we, mem_re, mem_sel, mem_addr, mem_wdata);
    end
    tick();
    host_req = 1'b0;
    tests++;
    if ({mem_we, mem_re, mem_sel, mem_addr} !== {1'b0, 1'b1, 2'd1, 12'd7}) begin
      fails++; $display("FAIL hw_read_strobe: got we=%b re=%b sel=%0d addr=%h want 0 1 1 007", mem_we, mem_re, mem_sel, mem_addr);
    end
    tick();
    tests++; if (host_rvalid !== 1'b0 || mem_re !== 1'b0) begin fails++; $display("FAIL hw_rvalid_early: got rv=%b re=%b want 0 0", host_rvalid, mem_re); end
    tick();
    tests++;
    if (host_rvalid !== 1'b1 || host_rdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL hw_readback: got v=%b d=%h want 1 deadbeef", host_rvalid, host_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    logic seen;
    seen = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 16'd8; cmd_sel = 2'd2; cmd_addr = 12'h010;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({busy, mem_re, pipe_en, dump_valid, done, cmd_ready} !== 6'b000001 || mem_addr !== '0) begin
      fails++; $display("FAIL async_reset: got busy/re/en/dv/done/rdy=%b addr=%h want 000001 000", {busy, mem_re, pipe_en, dump_valid, done, cmd_ready}, mem_addr);
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin seen |= dump_valid | mem_re; tick(); end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL reset_no_dump: got %b want 0", seen); end
    // RUN of zero cycles completes immediately.
    seen = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 16'd0;
    tick();
    cmd_valid = 1'b0;
    tests++; if ({done, pipe_en, busy} !== 3'b100) begin fails++; $display("FAIL run0_done: got done/en/busy=%b want 100", {done, pipe_en, busy}); end
    tick();
    tests++; if ({done, pipe_en} !== 2'b00) begin fails++; $display("FAIL run0_after: got done/en=%b want 00", {done, pipe_en}); end
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0; cmd_sel = 2'd0; cmd_addr = '0;
    abort = 1'b0; host_req = 1'b0; host_we = 1'b0; host_sel = 2'd0; host_addr = '0; host_wdata = '0;
    test_reset();
    test_run();
    test_dump();
    test_arbitration();
    test_abort();
    test_host_write_read();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
